// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable serial pattern detector with match counting.
// A pattern, length, overlap mode and match target are loaded in IDLE. A
// run then scans a 1-bit stream, pulses out per match, and finishes with a
// done pulse once the target count is reached.
// Optional build macro SEQ_TIMEOUT_EN adds a no-match timeout that aborts a
// run after TIMEOUT RUN cycles without a match. Without it, timeout is tied 0.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | accepting configuration, waiting for start
// RUN     | scanning in/in_valid, counting matches
// DONE    | target reached; one cycle carrying the done pulse, then IDLE
module seq_det_ctrl #(
  parameter int PAT_W   = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64,
  localparam int LEN_W  = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  output logic             cfg_err,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reset configuration is the classic non-overlapping 0110 detector.
  localparam logic [PAT_W-1:0] RST_PAT = PAT_W'(6);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(4);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic             cfg_legal;
  logic             hit;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmo_q, tmo_d;
`endif

  // Detector helpers: candidate history, saturating fill, length mask, match
  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], in};
    fill_inc   = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    hit       = in_valid && (fill_inc == len_q) &&
                ((hist_shift & len_mask) == (pat_q & len_mask));
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
  end

  // Next state, config latch, run datapath and one-cycle output pulses
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    tgt_d   = tgt_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    out_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    tmr_d   = tmr_q;
    tmo_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cfg_legal) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
            tgt_d = cfg_target;
          end else begin
            err_d = 1'b1;
          end
        end
        if (start) begin
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef SEQ_TIMEOUT_EN
          tmr_d   = TMR_LOAD;
`endif
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if (in_valid) begin
            hist_d = hist_shift;
            // Non-overlap restarts the fill so no bit is shared by two matches
            fill_d = (hit && !ovl_q) ? '0 : fill_inc;
          end
          if (hit) begin
            out_d = 1'b1;
            cnt_d = cnt_inc;
            if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end
`ifdef SEQ_TIMEOUT_EN
          // A match in the terminal cycle wins and reloads the timer
          if (hit) begin
            tmr_d = TMR_LOAD;
          end else if (tmr_q == '0) begin
            tmo_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, configuration and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= RST_PAT;
      len_q   <= RST_LEN;
      ovl_q   <= 1'b0;
      tgt_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      tgt_q   <= tgt_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  // No-match down-counter and its timeout pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign timeout = 1'b0;
`endif

  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign out       = out_q;
  assign done      = done_q;
  assign cfg_err   = err_q;
  assign match_cnt = cnt_q;

endmodule
